// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache AXI4 master bridge.
// States, AXI encodings and burst geometry helpers.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_CAP,
    AW,
    W,
    B,
    AR,
    R,
    LD
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int calc_blocks(input int block_size,
                                     input int data_size);
    return (2 ** block_size) / (data_size / 8);
  endfunction

  function automatic int calc_axsize(input int data_size);
    return $clog2(data_size / 8);
  endfunction

endpackage

// File: rtl/cache_line_buffer.sv
// One cache line of storage: whole-line load, indexed word write,
// indexed word read and full-line output.
module cache_line_buffer #(
  parameter int BLOCKS    = 16,
  parameter int DATA_SIZE = 32,
  parameter int IDX_W     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_en,
  input  logic [BLOCKS-1:0][DATA_SIZE-1:0] load_data,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [DATA_SIZE-1:0]             wr_data,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [DATA_SIZE-1:0]             rd_data,
  output logic [BLOCKS-1:0][DATA_SIZE-1:0] line
);

  logic [BLOCKS-1:0][DATA_SIZE-1:0] mem;

  // Line load wins over a single-word write; both never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (load_en) begin
      mem <= load_data;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
  assign line    = mem;

endmodule

// File: rtl/cache_axi_master.sv
// Line-granular AXI4 master: write-back and refill bursts, one at a time.
// Optional watchdog enabled with macro AXI_TIMEOUT_EN.
module cache_axi_master
  import cache_axi_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int BLOCKS     = calc_blocks(BLOCK_SIZE, DATA_SIZE),
  parameter int ID_W       = 4,
  parameter int AXI_ID     = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             addr_valid_in,
  input  logic [ADDR_SIZE-1:0]             addr_in,
  input  logic                             rw_in,
  output logic                             busy,
  input  logic                             valid_wb,
  output logic                             ready_wb,
  input  logic [BLOCKS-1:0][DATA_SIZE-1:0] data_wb,
  output logic                             valid_ld,
  input  logic                             ready_ld,
  output logic [BLOCKS-1:0][DATA_SIZE-1:0] data_ld,
  output logic                             err,
  output logic [ID_W-1:0]                  awid,
  output logic [ADDR_SIZE-1:0]             awaddr,
  output logic [7:0]                       awlen,
  output logic [2:0]                       awsize,
  output logic [1:0]                       awburst,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [DATA_SIZE-1:0]             wdata,
  output logic [DATA_SIZE/8-1:0]           wstrb,
  output logic                             wlast,
  output logic                             wvalid,
  input  logic                             wready,
  output logic                             bready,
  input  logic [ID_W-1:0]                  bid,
  input  logic [1:0]                       bresp,
  input  logic                             bvalid,
  output logic [ID_W-1:0]                  arid,
  output logic [ADDR_SIZE-1:0]             araddr,
  output logic [7:0]                       arlen,
  output logic [2:0]                       arsize,
  output logic [1:0]                       arburst,
  output logic                             arvalid,
  input  logic                             arready,
  output logic                             rready,
  input  logic [ID_W-1:0]                  rid,
  input  logic [DATA_SIZE-1:0]             rdata,
  input  logic [1:0]                       rresp,
  input  logic                             rlast,
  input  logic                             rvalid
);

  localparam int IDX_W = $clog2(BLOCKS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCKS - 1);
  localparam logic [2:0] AXSIZE = 3'(calc_axsize(DATA_SIZE));
  localparam logic [7:0] AXLEN = 8'(BLOCKS - 1);

  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic tmo_fire;

  assign busy     = state_q != IDLE;
  assign ready_wb = state_q == WB_CAP;
  assign awvalid  = state_q == AW;
  assign wvalid   = state_q == W;
  assign wlast    = (state_q == W) && (cnt_q == LAST);
  assign bready   = state_q == B;
  assign arvalid  = state_q == AR;
  assign rready   = state_q == R;
  assign valid_ld = state_q == LD;
  assign err      = err_q;

  assign awid    = ID_W'(AXI_ID);
  assign arid    = ID_W'(AXI_ID);
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = AXLEN;
  assign arlen   = AXLEN;
  assign awsize  = AXSIZE;
  assign arsize  = AXSIZE;
  assign awburst = BURST_INCR;
  assign arburst = BURST_INCR;
  assign wstrb   = '1;

  cache_line_buffer #(
    .BLOCKS    (BLOCKS),
    .DATA_SIZE (DATA_SIZE),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   ((state_q == WB_CAP) && valid_wb),
    .load_data (data_wb),
    .wr_en     ((state_q == R) && rvalid),
    .wr_idx    (cnt_q),
    .wr_data   (rdata),
    .rd_idx    (cnt_q),
    .rd_data   (wdata),
    .line      (data_ld)
  );

`ifdef AXI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic tmo_act, tmo_hs;

  assign tmo_act = state_q inside {AW, W, B, AR, R};
  assign tmo_hs = (awvalid & awready) | (wvalid & wready) |
                  (bvalid & bready) | (arvalid & arready) |
                  (rvalid & rready);
  assign tmo_fire = tmo_act & ~tmo_hs &
                    (tmo_q == TW'(TIMEOUT - 1));

  // Watchdog: counts stalled cycles since the last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!tmo_act || tmo_hs) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign tmo_fire   = 1'b0;
  assign unused_tmo = 32'(TIMEOUT);
`endif

  logic unused_in;
  assign unused_in = ^{rid, bid, addr_in[BLOCK_SIZE-1:0]};

  // Next state, beat counter and sticky error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (addr_valid_in) state_d = rw_in ? WB_CAP : AR;
      WB_CAP: if (valid_wb) state_d = AW;
      AW: if (awready) begin
        state_d = W;
        cnt_d   = '0;
      end
      W: if (wready) begin
        if (cnt_q == LAST) state_d = B;
        else cnt_d = cnt_q + 1'b1;
      end
      B: if (bvalid) begin
        state_d = IDLE;
        if (bresp != RESP_OKAY) err_d = 1'b1;
      end
      AR: if (arready) begin
        state_d = R;
        cnt_d   = '0;
      end
      R: if (rvalid) begin
        if (rresp != RESP_OKAY) err_d = 1'b1;
        if (rlast || cnt_q == LAST) begin
          state_d = LD;
          if (rlast != (cnt_q == LAST)) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LD: if (ready_ld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_fire) begin
      err_d   = 1'b1;
      state_d = (state_q == AR || state_q == R) ? LD : IDLE;
    end
  end

  // State, counter, error and latched line address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == IDLE && addr_valid_in) begin
        addr_q <= {addr_in[ADDR_SIZE-1:BLOCK_SIZE],
                   BLOCK_SIZE'(0)};
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_master.sv
// Bench for cache_axi_master: vector table of bursts, AXI slave model,
// W-beat/line scoreboard, reset, error and watchdog sequences.
module tb_cache_axi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic addr_valid_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic rw_in = 1'b0;
  logic busy;
  logic valid_wb = 1'b0;
  logic ready_wb;
  logic [15:0][31:0] data_wb = '0;
  logic valid_ld;
  logic ready_ld = 1'b0;
  logic [15:0][31:0] data_ld;
  logic err;
  logic [3:0] awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic awvalid, wvalid, wlast, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic [3:0] bid = '0, rid = '0;
  logic [1:0] bresp = '0, rresp = '0;
  logic bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = '0;

  cache_axi_master #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_valid_in(addr_valid_in), .addr_in(addr_in),
    .rw_in(rw_in), .busy(busy),
    .valid_wb(valid_wb), .ready_wb(ready_wb), .data_wb(data_wb),
    .valid_ld(valid_ld), .ready_ld(ready_ld), .data_ld(data_ld),
    .err(err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bready(bready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] base;
    bit          stall;
    bit          gap;
    logic [1:0]  resp;
    int          nbeats;
    int          hold;
    logic [31:0] exp_addr;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];
  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] line_model[16];
  logic [31:0] exp_axaddr = '0;
  int w_cnt = 0;

  bit aw_rand = 0, w_rand = 0, r_gap = 0, ar_block = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int r_nbeats = 16;
  logic [31:0] r_base = '0;
  bit r_active = 0;
  int r_beat = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AXI slave model: readies, B response, R burst generator.
  initial begin
    bit wl_hs, b_hs, ar_hs, r_hs;
    forever begin
      @(negedge clk);
      wl_hs = wvalid && wready && wlast;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; rvalid = 0; rlast = 0; r_active = 0;
      end else begin
        awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = !ar_block;
        if (wl_hs) begin
          bvalid = 1; bresp = bresp_cfg;
        end else if (b_hs) begin
          bvalid = 0;
        end
        if (ar_hs) begin
          r_active = 1; r_beat = 0;
        end
        if (r_hs) begin
          r_beat++;
          if (r_beat == r_nbeats) r_active = 0;
        end
        rvalid = r_active && (r_gap ? 1'($urandom_range(0, 1)) : 1'b1);
        rdata = r_base + 32'(r_beat);
        rlast = r_active && (r_beat == r_nbeats - 1);
        rresp = 2'b00;
      end
    end
  end

  // Monitor: AW/AR attributes, payload stability, W-beat scoreboard.
  initial begin
    bit aw_pend, w_pend;
    logic [31:0] aw_prev, w_prev;
    logic [31:0] e;
    aw_pend = 0; w_pend = 0; aw_prev = '0; w_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_pend = 0; w_pend = 0;
      end else begin
        if (awvalid) begin
          chk("awaddr", awaddr, exp_axaddr);
          chk("awlen", awlen, 15);
          chk("awsize", awsize, 2);
          chk("awburst", awburst, 1);
          if (aw_pend) chk("awaddr_stable", awaddr, aw_prev);
        end
        if (arvalid) begin
          chk("araddr", araddr, exp_axaddr);
          chk("arlen", arlen, 15);
          chk("arsize", arsize, 2);
          chk("arburst", arburst, 1);
        end
        if (wvalid) begin
          chk("wstrb", wstrb, 4'hF);
          if (w_pend) chk("wdata_stable", wdata, w_prev);
        end
        if (wvalid && wready) begin
          chk("w_queue_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wdata", wdata, e);
          end
          chk("wlast", wlast, w_cnt == 15);
          w_cnt++;
        end
        aw_pend = awvalid && !awready; aw_prev = awaddr;
        w_pend = wvalid && !wready; w_prev = wdata;
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int k;
    logic [31:0] e;
    exp_axaddr = v.exp_addr;
    aw_rand = v.stall; w_rand = v.stall;
    bresp_cfg = v.resp; r_gap = v.gap;
    r_nbeats = v.nbeats; r_base = v.base; w_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (v.rw) begin
        data_wb[i] = v.base + 32'(i);
        line_model[i] = v.base + 32'(i);
      end else if (i < v.nbeats) begin
        line_model[i] = v.base + 32'(i);
      end
      exp_q.push_back(line_model[i]);
    end
    addr_in = v.addr; rw_in = v.rw; addr_valid_in = 1;
    step();
    addr_valid_in = 0;
    chk("busy_start", busy, 1);
    if (v.rw) begin
      valid_wb = 1;
      chk("ready_wb", ready_wb, 1);
      step();
      valid_wb = 0;
      @(negedge clk);
      chk("ready_wb_drop", ready_wb, 0);
    end else begin
      k = 0;
      while (!valid_ld && k < 200) begin step(); k++; end
      chk("valid_ld", valid_ld, 1);
      for (int h = 0; h < v.hold; h++) begin
        step();
        chk("valid_ld_held", valid_ld, 1);
      end
      chk("ld_queue_size", exp_q.size(), 16);
      for (int i = 0; i < 16; i++) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("data_ld[%0d]", i), data_ld[i], e);
        end
      end
      ready_ld = 1;
      step();
      ready_ld = 0;
    end
    k = 0;
    while (busy && k < 300) begin step(); k++; end
    chk("busy_done", busy, 0);
    chk("err", err, v.exp_err);
    if (v.rw) begin
      chk("w_beats", w_cnt, 16);
      chk("w_queue_empty", exp_q.size(), 0);
    end
    aw_rand = 0; w_rand = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) line_model[i] = '0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready_wb"}, ready_wb, 0);
    chk({tag, "_valid_ld"}, valid_ld, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_wlast"}, wlast, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_data_ld"}, data_ld, '0);
    chk({tag, "_wdata"}, wdata, 0);
  endtask

  initial begin
    int k;
    vecs[0] = '{1, 'h0000_1234, 'hA000_0000, 0, 0, 2'b00, 16, 0, 'h0000_1200, 0};
    vecs[1] = '{0, 'h0000_2040, 'hB000_0000, 0, 1, 2'b00, 16, 5, 'h0000_2040, 0};
    vecs[2] = '{1, 'h0000_3FFC, 'hC000_0000, 1, 0, 2'b00, 16, 0, 'h0000_3FC0, 0};
    vecs[3] = '{0, 'h0000_507F, 'hD000_0000, 0, 0, 2'b00, 16, 0, 'h0000_5040, 0};
    vecs[4] = '{1, 'h0000_6010, 'hE000_0000, 1, 0, 2'b10, 16, 0, 'h0000_6000, 1};
    vecs[5] = '{0, 'h0000_8844, 'h2222_0000, 0, 1, 2'b00, 16, 0, 'h0000_8840, 0};
    vecs[6] = '{0, 'h0000_9000, 'h3333_0000, 0, 0, 2'b00, 10, 1, 'h0000_9000, 1};
    for (int i = 0; i < 16; i++) line_model[i] = '0;

    #1;
    chk_idle_outputs("reset");
    step();
    step();
    rst_n = 1;
    step();

    for (int n = 0; n < 5; n++) run_txn(vecs[n]);

    // Reset in the middle of a write burst, at W beat 7.
    exp_axaddr = 32'h0000_A000; w_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      data_wb[i] = 32'h1111_0000 + 32'(i);
      exp_q.push_back(data_wb[i]);
    end
    addr_in = 32'h0000_A000; rw_in = 1; addr_valid_in = 1;
    step();
    addr_valid_in = 0; valid_wb = 1;
    step();
    valid_wb = 0;
    k = 0;
    while (w_cnt < 7 && k < 100) begin @(posedge clk); k++; end
    chk("w_beats_before_reset", w_cnt, 7);
    #2;
    chk("wvalid_before_reset", wvalid, 1);
    rst_n = 0;
    #1;
    chk_idle_outputs("midreset");
    exp_q.delete();
    for (int i = 0; i < 16; i++) line_model[i] = '0;
    step();
    step();
    rst_n = 1;
    step();
    chk("busy_after_reset", busy, 0);

    run_txn(vecs[5]);
    run_txn(vecs[6]);

    // Watchdog: AR never accepted.
    do_reset();
    ar_block = 1;
    exp_axaddr = 32'h0000_B000;
    addr_in = 32'h0000_B000; rw_in = 0; addr_valid_in = 1;
    step();
    addr_valid_in = 0;
`ifdef AXI_TIMEOUT_EN
    k = 0;
    while (!valid_ld && k < 40) begin step(); k++; end
    chk("tmo_valid_ld", valid_ld, 1);
    chk("tmo_err", err, 1);
    chk("tmo_cycles_in_range", (k >= 15) && (k <= 17), 1);
    ready_ld = 1;
    step();
    ready_ld = 0;
    step();
    chk("tmo_busy_done", busy, 0);
`else
    repeat (40) step();
    chk("hang_busy", busy, 1);
    chk("hang_arvalid", arvalid, 1);
    chk("hang_valid_ld", valid_ld, 0);
    chk("hang_err", err, 0);
`endif
    ar_block = 0;
    do_reset();
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
